// File: rtl/keypoint_pkg.sv
// Types and constants shared by the keypoint detect/filter writer and the merge reader.
// A keypoint word is {row, col}, so comparing the packed word compares in raster order.
package keypoint_pkg;

  localparam int KP_W         = 19;
  localparam int ROW_W        = 9;
  localparam int COL_W        = 10;
  localparam int ADDR_W       = 11;
  localparam int MAX_KEYPOINT = 2048;
  localparam int CNT_W        = 12;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } kp_word_t;

  typedef enum logic [2:0] {
    KP_IDLE     = 3'd0,
    KP_PREFETCH = 3'd1,
    KP_FILL     = 3'd2,
    KP_STREAM   = 3'd3,
    KP_DONE     = 3'd4
  } kp_state_e;

  function automatic logic [CNT_W-1:0] kp_clamp(input logic [CNT_W-1:0] count,
                                                input logic [CNT_W-1:0] limit);
    return (count > limit) ? limit : count;
  endfunction

endpackage

// File: rtl/kp_bank_head.sv
// Read side of one keypoint SRAM: read pointer, one-word head register and refill tracking.
// A pop consumes the head and, if words remain, issues the read that refills it next cycle.
module kp_bank_head
  import keypoint_pkg::*;
#(
  parameter int MAX_KEYPOINT = keypoint_pkg::MAX_KEYPOINT,
  parameter int ADDR_W       = keypoint_pkg::ADDR_W,
  parameter int KP_W         = keypoint_pkg::KP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [CNT_W-1:0]  i_count,
  input  logic              i_pop,
  output logic              o_re,
  output logic [ADDR_W-1:0] o_addr,
  input  logic [KP_W-1:0]   i_dout,
  output logic [KP_W-1:0]   o_head,
  output logic [KP_W-1:0]   o_key,
  output logic              o_head_valid,
  output logic              o_avail,
  output logic              o_at_end,
  output logic              o_exhausted
);

  logic [CNT_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_count;
  logic [KP_W-1:0]  r_head;
  logic             r_head_valid;
  logic             r_pending;
  logic             w_at_end;
  logic             w_issue;

  assign w_at_end = (r_ptr == r_count);
  assign w_issue  = i_pop && !w_at_end;

  assign o_re         = w_issue;
  assign o_addr       = r_ptr[ADDR_W-1:0];
  assign o_head       = r_head;
  // While a refill is in flight the word on dout is the next head; expose it for comparison.
  assign o_key        = r_pending ? i_dout : r_head;
  assign o_head_valid = r_head_valid;
  assign o_avail      = r_head_valid || r_pending;
  assign o_at_end     = w_at_end;
  assign o_exhausted  = w_at_end && !r_head_valid && !r_pending;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr        <= '0;
      r_count      <= '0;
      r_head       <= '0;
      r_head_valid <= 1'b0;
      r_pending    <= 1'b0;
    end else if (i_load) begin
      r_count      <= kp_clamp(i_count, CNT_W'(MAX_KEYPOINT));
      r_ptr        <= '0;
      r_head_valid <= 1'b0;
      r_pending    <= 1'b0;
    end else begin
      if (r_pending) begin
        r_head       <= i_dout;
        r_head_valid <= 1'b1;
      end
      if (i_pop) begin
        r_head_valid <= 1'b0;
      end
      r_pending <= w_issue;
      if (w_issue) begin
        r_ptr <= r_ptr + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/keypoint_merge_reader.sv
// Two-way raster-order merge of the two keypoint SRAMs into one tagged keypoint stream.
// Ties go to bank 1; the output register is a single-entry valid/ready stage.
module keypoint_merge_reader
  import keypoint_pkg::*;
#(
  parameter int MAX_KEYPOINT = keypoint_pkg::MAX_KEYPOINT,
  parameter int ADDR_W       = keypoint_pkg::ADDR_W,
  parameter int KP_W         = keypoint_pkg::KP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [11:0]       kp1_count,
  input  logic [11:0]       kp2_count,
  output logic              kp1_re,
  output logic [ADDR_W-1:0] kp1_addr,
  input  logic [KP_W-1:0]   kp1_dout,
  output logic              kp2_re,
  output logic [ADDR_W-1:0] kp2_addr,
  input  logic [KP_W-1:0]   kp2_dout,
  output logic              kp_valid,
  input  logic              kp_ready,
  output logic [8:0]        kp_row,
  output logic [9:0]        kp_col,
  output logic              kp_scale,
  output logic              kp_last,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE     = KP_IDLE;
  localparam logic [2:0] S_PREFETCH = KP_PREFETCH;
  localparam logic [2:0] S_FILL     = KP_FILL;
  localparam logic [2:0] S_STREAM   = KP_STREAM;
  localparam logic [2:0] S_DONE     = KP_DONE;

  logic [2:0]      r_state;
  logic            r_valid;
  logic            r_scale;
  logic            r_last;
  kp_word_t        r_word;

  logic            w_load;
  logic            w_pop1;
  logic            w_pop2;
  logic            w_free;
  logic            w_sel1;
  logic            w_sel2;
  logic            w_last;
  logic            w_accept_last;
  logic [KP_W-1:0] w_head1;
  logic [KP_W-1:0] w_head2;
  logic [KP_W-1:0] w_key1;
  logic [KP_W-1:0] w_key2;
  logic            w_hv1;
  logic            w_hv2;
  logic            w_avail1;
  logic            w_avail2;
  logic            w_end1;
  logic            w_end2;
  logic            w_exh1;
  logic            w_exh2;

  assign w_load = (r_state == S_IDLE) && start;
  assign w_free = !r_valid || kp_ready;

  // A bank may only be chosen from a captured head; the other bank's in-flight word still counts.
  assign w_sel1 = (r_state == S_STREAM) && w_free && w_hv1 &&
                  (w_exh2 || (w_avail2 && (w_head1 <= w_key2)));
  assign w_sel2 = (r_state == S_STREAM) && w_free && w_hv2 &&
                  (w_exh1 || (w_avail1 && (w_head2 < w_key1)));

  assign w_pop1 = (r_state == S_PREFETCH) || w_sel1;
  assign w_pop2 = (r_state == S_PREFETCH) || w_sel2;

  assign w_last        = w_sel1 ? (w_end1 && w_exh2) : (w_end2 && w_exh1);
  assign w_accept_last = r_valid && kp_ready && r_last;

  kp_bank_head #(.MAX_KEYPOINT(MAX_KEYPOINT), .ADDR_W(ADDR_W), .KP_W(KP_W)) u_bank1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_count     (kp1_count),
    .i_pop       (w_pop1),
    .o_re        (kp1_re),
    .o_addr      (kp1_addr),
    .i_dout      (kp1_dout),
    .o_head      (w_head1),
    .o_key       (w_key1),
    .o_head_valid(w_hv1),
    .o_avail     (w_avail1),
    .o_at_end    (w_end1),
    .o_exhausted (w_exh1)
  );

  kp_bank_head #(.MAX_KEYPOINT(MAX_KEYPOINT), .ADDR_W(ADDR_W), .KP_W(KP_W)) u_bank2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_count     (kp2_count),
    .i_pop       (w_pop2),
    .o_re        (kp2_re),
    .o_addr      (kp2_addr),
    .i_dout      (kp2_dout),
    .o_head      (w_head2),
    .o_key       (w_key2),
    .o_head_valid(w_hv2),
    .o_avail     (w_avail2),
    .o_at_end    (w_end2),
    .o_exhausted (w_exh2)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:     if (start) r_state <= S_PREFETCH;
        S_PREFETCH: r_state <= S_FILL;
        S_FILL:     r_state <= (w_exh1 && w_exh2) ? S_DONE : S_STREAM;
        S_STREAM:   if (w_accept_last) r_state <= S_DONE;
        S_DONE:     r_state <= S_IDLE;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_scale <= 1'b0;
      r_last  <= 1'b0;
      r_word  <= '0;
    end else if (w_sel1 || w_sel2) begin
      r_valid <= 1'b1;
      r_scale <= w_sel2;
      r_last  <= w_last;
      r_word  <= w_sel2 ? kp_word_t'(w_head2) : kp_word_t'(w_head1);
    end else if (kp_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign kp_valid = r_valid;
  assign kp_row   = r_word.row;
  assign kp_col   = r_word.col;
  assign kp_scale = r_scale;
  assign kp_last  = r_last;
  assign busy     = (r_state == S_PREFETCH) || (r_state == S_FILL) || (r_state == S_STREAM);
  assign done     = (r_state == S_DONE);

endmodule
